// File: rtl/rca_pkg.sv
// Shared widths and result type for the ripple-carry adder result FIFO.
package rca_pkg;

  localparam int RCA_W = 4;
  localparam int RES_W = 5;

  typedef logic [RES_W-1:0] rca_res_t;

  function automatic rca_res_t pack_result(input logic c, input logic [RCA_W-1:0] s);
    return {c, s};
  endfunction

endpackage

// File: rtl/rca_fifo_mem.sv
// DEPTH x RES_W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the FIFO masks the read data while empty.
module rca_fifo_mem
  import rca_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rca_res_t      wdata,
  input  logic [AW-1:0] raddr,
  output rca_res_t      rdata
);

  rca_res_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rca_result_fifo.sv
// Result FIFO for a 4-bit ripple-carry adder with a running accumulator.
// Define RCA_OVF_COUNT_EN to build the saturating carry-out counter behind ovf_cnt.
module rca_result_fifo
  import rca_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RCA_W-1:0]       sum,
  input  logic                   cout,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [RES_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   acc_clr,
  output logic [ACC_W-1:0]       acc,
  output logic [7:0]             ovf_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_add;
  rca_res_t         in_res;
  rca_res_t         head_res;
  logic             push;
  logic             pop;

  assign in_res  = pack_result(cout, sum);
  assign acc_add = ACC_W'(in_res);

  // Handshakes decode registered occupancy only, so a full FIFO refuses input even when popping.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A clear coinciding with a push restarts the total at the pushed value.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = push ? acc_add : '0;
    end else if (push) begin
      acc_d = acc_q + acc_add;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  rca_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_res),
    .raddr (rd_ptr_q),
    .rdata (head_res)
  );

  assign out_data = out_valid ? head_res : '0;
  assign count    = count_q;
  assign acc      = acc_q;

`ifdef RCA_OVF_COUNT_EN
  logic [7:0] ovf_q, ovf_d;
  logic       ovf_hit;

  assign ovf_hit = push && cout;

  always_comb begin
    ovf_d = ovf_q;
    if (acc_clr) begin
      ovf_d = ovf_hit ? 8'd1 : 8'd0;
    end else if (ovf_hit && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rca_result_fifo.sv
// Bench for rca_result_fifo: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_rca_result_fifo;

  localparam int DEPTH = 4;
  localparam int ACC_W = 8;
`ifdef RCA_OVF_COUNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sum;
  logic       cout;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       acc_clr;
  logic [7:0] acc;
  logic [7:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

  logic [4:0] mq[$];
  int         m_acc = 0;
  int         m_ovf = 0;
  bit         m_push;
  bit         m_pop;
  logic [4:0] m_val;

  logic [4:0] vals35 [5]  = '{5'h01, 5'h12, 5'h03, 5'h14, 5'h05};
  logic [4:0] seq36  [12] = '{5'h0A, 5'h0B, 5'h10, 5'h11, 5'h12, 5'h13,
                              5'h14, 5'h15, 5'h16, 5'h17, 5'h18, 5'h19};

  always #5 clk = ~clk;

  rca_result_fifo #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sum       (sum),
    .cout      (cout),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .acc_clr   (acc_clr),
    .acc       (acc),
    .ovf_cnt   (ovf_cnt)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] res, input logic ordy, input logic clr);
    in_valid  = v;
    cout      = res[4];
    sum       = res[3:0];
    out_ready = ordy;
    acc_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic int ovfExp(input int n);
    return OVF_EN ? ((n > 255) ? 255 : n) : 0;
  endfunction

  // Reference model: plain queue plus integer totals, updated per accepted transfer.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_acc = 0;
      m_ovf = 0;
    end else begin
      m_val  = {cout, sum};
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = out_ready && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_val);
      if (acc_clr) m_acc = m_push ? int'(m_val) : 0;
      else if (m_push) m_acc = (m_acc + int'(m_val)) % (1 << ACC_W);
      if (OVF_EN) begin
        if (acc_clr) m_ovf = (m_push && cout) ? 1 : 0;
        else if (m_push && cout && (m_ovf < 255)) m_ovf++;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("mdl_count",     int'(count),     mq.size());
    checkOutput("mdl_in_ready",  int'(in_ready),  (mq.size() != DEPTH) ? 1 : 0);
    checkOutput("mdl_out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
    checkOutput("mdl_out_data",  int'(out_data),  (mq.size() != 0) ? int'(mq[0]) : 0);
    checkOutput("mdl_acc",       int'(acc),       m_acc);
    checkOutput("mdl_ovf",       int'(ovf_cnt),   m_ovf);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    sum       = 4'h0;
    cout      = 1'b0;
    out_ready = 1'b0;
    acc_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count",     int'(count),     0);
    checkOutput("rst_in_ready",  int'(in_ready),  1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data",  int'(out_data),  0);
    checkOutput("rst_acc",       int'(acc),       0);
    checkOutput("rst_ovf",       int'(ovf_cnt),   0);
    rst = 1'b0;

    // First push into an empty FIFO shows up one cycle later.
    applyStimulus(1'b1, 5'h1F, 1'b0, 1'b0);
    checkOutput("first_out_valid", int'(out_valid), 1);
    checkOutput("first_out_data",  int'(out_data),  31);
    checkOutput("first_count",     int'(count),     1);
    checkOutput("first_acc",       int'(acc),       31);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0);
    checkOutput("first_drain_count", int'(count), 0);
    checkOutput("first_drain_data",  int'(out_data), 0);
    checkOutput("first_drain_acc",   int'(acc), 31);

    // Fill to full, fifth push refused, then full + pop refuses the input.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, vals35[i], 1'b0, 1'b0);
    checkOutput("full_count",    int'(count),    4);
    checkOutput("full_in_ready", int'(in_ready), 0);
    applyStimulus(1'b1, vals35[4], 1'b0, 1'b0);
    checkOutput("refused_count", int'(count), 4);
    checkOutput("refused_acc",   int'(acc),   73);
    checkOutput("full_head",     int'(out_data), int'(vals35[0]));
    applyStimulus(1'b1, 5'h06, 1'b1, 1'b0);
    checkOutput("full_pop_count", int'(count), 3);
    checkOutput("full_pop_acc",   int'(acc),   73);
    for (int i = 1; i < 4; i++) begin
      checkOutput("drain35_head", int'(out_data), int'(vals35[i]));
      applyStimulus(1'b0, 5'h00, 1'b1, 1'b0);
    end
    checkOutput("drain35_count", int'(count), 0);
    checkOutput("drain35_ovf",   int'(ovf_cnt), ovfExp(3));

    // Steady push+pop at occupancy 2; pointers wrap three times.
    applyStimulus(1'b0, 5'h00, 1'b0, 1'b1);
    checkOutput("clr_acc", int'(acc), 0);
    checkOutput("clr_ovf", int'(ovf_cnt), 0);
    applyStimulus(1'b1, seq36[0], 1'b0, 1'b0);
    applyStimulus(1'b1, seq36[1], 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("wrap_head", int'(out_data), int'(seq36[i]));
      applyStimulus(1'b1, seq36[i+2], 1'b1, 1'b0);
      checkOutput("wrap_count", int'(count), 2);
    end
    for (int i = 10; i < 12; i++) begin
      checkOutput("wrap_drain_head", int'(out_data), int'(seq36[i]));
      applyStimulus(1'b0, 5'h00, 1'b1, 1'b0);
    end
    checkOutput("wrap_acc", int'(acc), 226);
    checkOutput("wrap_ovf", int'(ovf_cnt), ovfExp(10));

    // Accumulator wraps modulo 256, then clear-with-push loads the pushed value.
    applyStimulus(1'b0, 5'h00, 1'b0, 1'b1);
    repeat (9) applyStimulus(1'b1, 5'h1F, 1'b1, 1'b0);
    checkOutput("acc_wrap", int'(acc), 23);
    checkOutput("acc_wrap_ovf", int'(ovf_cnt), ovfExp(9));
    applyStimulus(1'b1, 5'h03, 1'b1, 1'b1);
    checkOutput("clr_push_acc",  int'(acc), 3);
    checkOutput("clr_push_ovf",  int'(ovf_cnt), 0);
    checkOutput("clr_push_data", int'(out_data), 3);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0);

    // Carry-out counter saturation.
    applyStimulus(1'b0, 5'h00, 1'b0, 1'b1);
    repeat (300) applyStimulus(1'b1, 5'h10, 1'b1, 1'b0);
    checkOutput("sat_ovf", int'(ovf_cnt), OVF_EN ? 255 : 0);
    checkOutput("sat_acc", int'(acc), 192);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0);
    checkOutput("sat_drain_count", int'(count), 0);

    // Asynchronous reset between edges discards stored entries at once.
    applyStimulus(1'b1, 5'h07, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'h08, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'h09, 1'b0, 1'b0);
    checkOutput("prefill_count", int'(count), 3);
    checkOutput("prefill_acc",   int'(acc),   216);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("async_out_valid", int'(out_valid), 0);
    checkOutput("async_count",     int'(count),     0);
    checkOutput("async_acc",       int'(acc),       0);
    checkOutput("async_out_data",  int'(out_data),  0);
    checkOutput("async_in_ready",  int'(in_ready),  1);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 5'h15, 1'b0, 1'b0);
    checkOutput("post_rst_valid", int'(out_valid), 1);
    checkOutput("post_rst_data",  int'(out_data),  21);
    checkOutput("post_rst_count", int'(count),     1);
    checkOutput("post_rst_acc",   int'(acc),       21);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0);
    checkOutput("end_count", int'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
